// File: rtl/lagarto_l15_arb_pkg.sv
// Shared types for the Lagarto L1.5 request arbiter. The l15_req_t / l15_rtrn_t
// structs carry the subset of wt_cache_pkg fields this block touches.
package lagarto_l15_arb_pkg;

    localparam int L15_TAG_W = 3;
    localparam int L15_TID_W = L15_TAG_W;
    localparam int REQ_IDX_W = 2;

    // Invalidation/evict returns carry no tag and go to every requester
    localparam logic [3:0] L15_EVICT_RTYPE = 4'b0011;

    typedef struct packed {
        logic                 l15_val;
        logic [4:0]           l15_rqtype;
        logic                 l15_nc;
        logic [2:0]           l15_size;
        logic [L15_TID_W-1:0] l15_threadid;
        logic [39:0]          l15_address;
        logic [63:0]          l15_data;
    } l15_req_t;

    typedef struct packed {
        logic                 l15_header_ack;
        logic                 l15_val;
        logic [3:0]           l15_returntype;
        logic [L15_TID_W-1:0] l15_threadid;
        logic [63:0]          l15_data_0;
    } l15_rtrn_t;

    typedef struct packed {
        logic                 valid;
        logic [REQ_IDX_W-1:0] owner;
        logic [L15_TID_W-1:0] orig_threadid;
    } tag_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/lagarto_l15_req_arbiter_rr.sv
// Round-robin picker: grants the first requester at or after ptr, wrapping at NUM_REQ.
module lagarto_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    localparam logic [IDX_W:0] N = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0] cand;

    // Walk from farthest to nearest so the candidate closest to ptr wins last
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= N) cand = cand - N;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (req[r] && cand == (IDX_W+1)'(r)) begin
                    gnt     = '0;
                    gnt[r]  = 1'b1;
                    gnt_idx = IDX_W'(r);
                end
            end
        end
    end

endmodule

// File: rtl/lagarto_l15_req_arbiter.sv
// Shares the tile's L1.5 channel between NUM_REQ requesters with private threadid tags.
// Define LAGARTO_L15_ARB_PERF_EN to add grant and tag-stall performance counters.
module lagarto_l15_req_arbiter
    import lagarto_l15_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int MAX_OUTST = 4
) (
    input  logic               clk_i,
    input  logic               reset_l,
    input  logic [NUM_REQ-1:0] req_val_i,
    input  l15_req_t           req_i [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ack_o,
    output l15_req_t           l15_req_o,
    input  l15_rtrn_t          l15_rtrn_i,
    output logic [NUM_REQ-1:0] rtrn_val_o,
    output l15_rtrn_t          rtrn_o,
    output logic               tag_err_o,
    output arb_state_e         dbg_state_o
`ifdef LAGARTO_L15_ARB_PERF_EN
    ,
    output logic [31:0]        perf_grant_o [NUM_REQ],
    output logic [31:0]        perf_stall_o
`endif
);

    arb_state_e           state, state_nxt;
    tag_entry_t           tag_tbl [MAX_OUTST];
    logic [REQ_IDX_W-1:0] rr_ptr, owner, gnt_idx, hit_owner;
    logic [NUM_REQ-1:0]   gnt;
    logic [L15_TAG_W-1:0] free_tag, rtag;
    logic [L15_TID_W-1:0] hit_tid;
    logic                 free_any, grant, ack, hit, rtn_free, rtn_bad;
    l15_req_t             sel_req, issue_req, req_lat;

    lagarto_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(REQ_IDX_W)) u_rr (
        .req     (req_val_i),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        free_any = 1'b0;
        free_tag = '0;
        for (int t = MAX_OUTST - 1; t >= 0; t--) begin
            if (!tag_tbl[t].valid) begin
                free_any = 1'b1;
                free_tag = L15_TAG_W'(t);
            end
        end
    end

    // The issued copy carries the private tag in place of the requester's threadid
    always_comb begin
        sel_req = '0;
        for (int r = 0; r < NUM_REQ; r++)
            if (gnt[r]) sel_req = req_i[r];
        issue_req              = sel_req;
        issue_req.l15_val      = 1'b1;
        issue_req.l15_threadid = free_tag;
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   if (ack)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant       = 1'b0;
        ack         = 1'b0;
        l15_req_o   = '0;
        req_ack_o   = '0;
        dbg_state_o = state;
        case (state)
            IDLE: grant = (|gnt) && free_any;
            ISSUE: begin
                l15_req_o = req_lat;
                ack       = l15_rtrn_i.l15_header_ack;
                for (int r = 0; r < NUM_REQ; r++)
                    req_ack_o[r] = ack && (owner == REQ_IDX_W'(r));
            end
            default: ;
        endcase
    end

    always_comb begin
        rtag      = l15_rtrn_i.l15_threadid;
        hit       = 1'b0;
        hit_owner = '0;
        hit_tid   = '0;
        for (int t = 0; t < MAX_OUTST; t++) begin
            if (tag_tbl[t].valid && rtag == L15_TAG_W'(t)) begin
                hit       = 1'b1;
                hit_owner = tag_tbl[t].owner;
                hit_tid   = tag_tbl[t].orig_threadid;
            end
        end
    end

    always_comb begin
        rtrn_val_o = '0;
        rtrn_o     = '0;
        rtn_free   = 1'b0;
        rtn_bad    = 1'b0;
        if (l15_rtrn_i.l15_val) begin
            if (l15_rtrn_i.l15_returntype == L15_EVICT_RTYPE) begin
                rtrn_val_o = '1;
                rtrn_o     = l15_rtrn_i;
            end else if (hit) begin
                for (int r = 0; r < NUM_REQ; r++)
                    rtrn_val_o[r] = (hit_owner == REQ_IDX_W'(r));
                rtrn_o              = l15_rtrn_i;
                rtrn_o.l15_threadid = hit_tid;
                rtn_free            = 1'b1;
            end else begin
                rtn_bad = 1'b1;
            end
        end
    end

    // Allocation only looks at registered valids, so a tag freed this cycle is not reused until the next
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            req_lat   <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            tag_err_o <= 1'b0;
            for (int t = 0; t < MAX_OUTST; t++) tag_tbl[t] <= '0;
        end else begin
            if (grant) begin
                req_lat <= issue_req;
                owner   <= gnt_idx;
            end
            if (ack) rr_ptr <= (owner == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            if (rtn_bad) tag_err_o <= 1'b1;
            for (int t = 0; t < MAX_OUTST; t++) begin
                if (rtn_free && rtag == L15_TAG_W'(t)) tag_tbl[t].valid <= 1'b0;
                if (grant && free_tag == L15_TAG_W'(t))
                    tag_tbl[t] <= '{valid: 1'b1, owner: gnt_idx, orig_threadid: sel_req.l15_threadid};
            end
        end
    end

`ifdef LAGARTO_L15_ARB_PERF_EN
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            perf_stall_o <= '0;
            for (int r = 0; r < NUM_REQ; r++) perf_grant_o[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++)
                if (grant && gnt[r] && perf_grant_o[r] != '1) perf_grant_o[r] <= perf_grant_o[r] + 32'd1;
            if (state == IDLE && (|req_val_i) && !free_any && perf_stall_o != '1)
                perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lagarto_l15_req_arbiter.sv
// Directed bench for lagarto_l15_req_arbiter: requester and L15 agents, scoreboard monitor.
module tb_lagarto_l15_req_arbiter;
    import lagarto_l15_arb_pkg::*;

    localparam int NUM_REQ = 3;

    logic               clk_i = 1'b0;
    logic               reset_l;
    logic [NUM_REQ-1:0] req_val_i;
    l15_req_t           req_i [NUM_REQ];
    logic [NUM_REQ-1:0] req_ack_o;
    l15_req_t           l15_req_o;
    l15_rtrn_t          l15_rtrn_i;
    logic [NUM_REQ-1:0] rtrn_val_o;
    l15_rtrn_t          rtrn_o;
    logic               tag_err_o;
    arb_state_e         dbg_state_o;

    logic       hack, rval;
    logic [3:0] rtype;
    logic [2:0] rtid;

    // Scoreboard entries: issue = {req_ack one-hot, tag, addr[15:0]}, return = {rtrn_val, threadid}
    logic [21:0] exp_issue_q[$];
    logic [5:0]  exp_rtrn_q[$];
    logic [15:0] pend_q [NUM_REQ][$];
    logic [6:0]  rcmd_q[$];

    int checks = 0;
    int failures = 0;
    int ack_delay = 1;
    bit auto_rtrn = 1'b0;
    int val_len = 0;
    int hs_len = 0;
    int l15_cnt = 0;
    logic [NUM_REQ-1:0] ack_seen;

    lagarto_l15_req_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUTST(4)) dut (
        .clk_i       (clk_i),
        .reset_l     (reset_l),
        .req_val_i   (req_val_i),
        .req_i       (req_i),
        .req_ack_o   (req_ack_o),
        .l15_req_o   (l15_req_o),
        .l15_rtrn_i  (l15_rtrn_i),
        .rtrn_val_o  (rtrn_val_o),
        .rtrn_o      (rtrn_o),
        .tag_err_o   (tag_err_o),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        l15_rtrn_i                = '0;
        l15_rtrn_i.l15_header_ack = hack;
        l15_rtrn_i.l15_val        = rval;
        l15_rtrn_i.l15_returntype = rtype;
        l15_rtrn_i.l15_threadid   = rtid;
        l15_rtrn_i.l15_data_0     = 64'h0000_00d0_0000_00d0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_issue_q.size() > 0 || exp_rtrn_q.size() > 0 || rcmd_q.size() > 0) && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s actual=issue:%0d,rtrn:%0d pending required=drained", name,
                     exp_issue_q.size(), exp_rtrn_q.size());
            exp_issue_q.delete();
            exp_rtrn_q.delete();
            rcmd_q.delete();
        end
        tick(2);
    endtask

    // Requester agent: holds the head item until its req_ack pulse, then presents the next one
    initial begin
        ack_seen  = '0;
        req_val_i = '0;
        for (int r = 0; r < NUM_REQ; r++) req_i[r] = '0;
        forever begin
            @(negedge clk_i);
            ack_seen = req_ack_o;
            @(posedge clk_i);
            #1;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (ack_seen[r] && pend_q[r].size() > 0) void'(pend_q[r].pop_front());
                req_val_i[r] = (pend_q[r].size() > 0);
                req_i[r]     = '0;
                if (pend_q[r].size() > 0) begin
                    req_i[r].l15_address  = {24'h0, pend_q[r][0]};
                    req_i[r].l15_threadid = pend_q[r][0][2:0];
                    req_i[r].l15_size     = 3'd3;
                end
            end
        end
    end

    // L15 agent: header_ack after ack_delay cycles of l15_val; returns from a command queue or auto-return
    initial begin
        logic [6:0] c;
        hack = 1'b0; rval = 1'b0; rtype = '0; rtid = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (l15_req_o.l15_val) l15_cnt++;
            else                   l15_cnt = 0;
            hack  = l15_req_o.l15_val && (l15_cnt >= ack_delay);
            rval  = 1'b0;
            rtype = '0;
            rtid  = '0;
            if (auto_rtrn && hack) begin
                rval = 1'b1;
                rtid = l15_req_o.l15_threadid;
            end else if (rcmd_q.size() > 0) begin
                c     = rcmd_q.pop_front();
                rval  = 1'b1;
                rtype = c[6:3];
                rtid  = c[2:0];
            end
        end
    end

    // Monitor: compares every handshake and every routed return against the scoreboard
    initial begin
        logic [21:0] exp_i;
        logic [5:0]  exp_r;
        forever begin
            @(negedge clk_i);
            if (l15_req_o.l15_val) val_len++;
            else                   val_len = 0;
            if (l15_req_o.l15_val && l15_rtrn_i.l15_header_ack) begin
                hs_len  = val_len;
                val_len = 0;
                if (exp_issue_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL issue_unexpected actual=%0h required=none",
                             {req_ack_o, l15_req_o.l15_threadid, l15_req_o.l15_address[15:0]});
                end else begin
                    exp_i = exp_issue_q.pop_front();
                    check("issue", 64'({req_ack_o, l15_req_o.l15_threadid, l15_req_o.l15_address[15:0]}), 64'(exp_i));
                end
            end else if (req_ack_o != '0) begin
                checks++; failures++;
                $display("FAIL spurious_ack actual=%0h required=0", req_ack_o);
            end
            if (rtrn_val_o != '0) begin
                if (exp_rtrn_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rtrn_unexpected actual=%0h required=none", {rtrn_val_o, rtrn_o.l15_threadid});
                end else begin
                    exp_r = exp_rtrn_q.pop_front();
                    check("rtrn", 64'({rtrn_val_o, rtrn_o.l15_threadid}), 64'(exp_r));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_l = 1'b0;
        tick(3);
        check("rst_l15_val", 64'(l15_req_o.l15_val), 64'd0);
        check("rst_req_ack", 64'(req_ack_o), 64'd0);
        check("rst_rtrn_val", 64'(rtrn_val_o), 64'd0);
        check("rst_tag_err", 64'(tag_err_o), 64'd0);
        check("rst_state", 64'(dbg_state_o), 64'(IDLE));
        reset_l = 1'b1;
        tick(2);

        // Single icache request, ack after 3 cycles of l15_val
        ack_delay = 3;
        exp_issue_q.push_back({3'b001, 3'd0, 16'h1011});
        pend_q[0].push_back(16'h1011);
        wait_drain("t1_issue_drain", 40);
        check("t1_val_len", 64'(hs_len), 64'd3);
        exp_rtrn_q.push_back({3'b001, 3'd1});
        rcmd_q.push_back({4'h0, 3'd0});
        wait_drain("t1_rtrn_drain", 20);

        // Reset puts rr_ptr back to 0, then three busy requesters with immediate ack + return
        reset_l = 1'b0;
        tick(1);
        reset_l = 1'b1;
        tick(1);
        ack_delay = 1;
        auto_rtrn = 1'b1;
        exp_issue_q.push_back({3'b001, 3'd0, 16'h2001});
        exp_issue_q.push_back({3'b010, 3'd0, 16'h2103});
        exp_issue_q.push_back({3'b100, 3'd0, 16'h2205});
        exp_issue_q.push_back({3'b001, 3'd0, 16'h2002});
        exp_issue_q.push_back({3'b010, 3'd0, 16'h2104});
        exp_issue_q.push_back({3'b100, 3'd0, 16'h2206});
        exp_rtrn_q.push_back({3'b001, 3'd1});
        exp_rtrn_q.push_back({3'b010, 3'd3});
        exp_rtrn_q.push_back({3'b100, 3'd5});
        exp_rtrn_q.push_back({3'b001, 3'd2});
        exp_rtrn_q.push_back({3'b010, 3'd4});
        exp_rtrn_q.push_back({3'b100, 3'd6});
        pend_q[0].push_back(16'h2001); pend_q[0].push_back(16'h2002);
        pend_q[1].push_back(16'h2103); pend_q[1].push_back(16'h2104);
        pend_q[2].push_back(16'h2205); pend_q[2].push_back(16'h2206);
        wait_drain("t2_rr_drain", 60);
        auto_rtrn = 1'b0;

        // Five dcache requests without returns: four tags, fifth waits until tag 2 comes back
        for (int i = 1; i <= 5; i++) pend_q[1].push_back(16'h3010 + 16'(i));
        for (int i = 0; i < 4; i++) exp_issue_q.push_back({3'b010, 3'(i), 16'h3011 + 16'(i)});
        wait_drain("t3_four_drain", 60);
        tick(6);
        check("t3_fifth_waits", 64'(l15_req_o.l15_val), 64'd0);
        check("t3_idle", 64'(dbg_state_o), 64'(IDLE));
        exp_rtrn_q.push_back({3'b010, 3'd3});
        exp_issue_q.push_back({3'b010, 3'd2, 16'h3015});
        rcmd_q.push_back({4'h0, 3'd2});
        wait_drain("t3_reuse_drain", 30);

        // Out-of-order returns restore original threadids
        exp_rtrn_q.push_back({3'b010, 3'd2});
        exp_rtrn_q.push_back({3'b010, 3'd1});
        exp_rtrn_q.push_back({3'b010, 3'd4});
        exp_rtrn_q.push_back({3'b010, 3'd5});
        rcmd_q.push_back({4'h0, 3'd1});
        rcmd_q.push_back({4'h0, 3'd0});
        rcmd_q.push_back({4'h0, 3'd3});
        rcmd_q.push_back({4'h0, 3'd2});
        wait_drain("t4_ooo_drain", 30);

        // Evict broadcast, then returns with unallocated tags
        exp_rtrn_q.push_back({3'b111, 3'd6});
        rcmd_q.push_back({L15_EVICT_RTYPE, 3'd6});
        wait_drain("t5_evict_drain", 20);
        check("t5_no_err_yet", 64'(tag_err_o), 64'd0);
        rcmd_q.push_back({4'h0, 3'd5});
        tick(4);
        check("t5_tag_err", 64'(tag_err_o), 64'd1);
        rcmd_q.push_back({4'h0, 3'd0});
        tick(6);
        check("t5_tag_err_sticky", 64'(tag_err_o), 64'd1);

        // Reset while a request sits in ISSUE
        ack_delay = 10;
        pend_q[2].push_back(16'h4001);
        n = 0;
        while (!l15_req_o.l15_val && n < 20) begin
            tick(1);
            n++;
        end
        check("t6_reached_issue", 64'(l15_req_o.l15_val), 64'd1);
        reset_l = 1'b0;
        #1;
        check("t6_async_drop", 64'(l15_req_o.l15_val), 64'd0);
        pend_q[2].delete();
        tick(2);
        reset_l = 1'b1;
        tick(1);
        check("t6_state_idle", 64'(dbg_state_o), 64'(IDLE));
        check("t6_err_cleared", 64'(tag_err_o), 64'd0);
        ack_delay = 1;
        rcmd_q.push_back({4'h0, 3'd0});
        tick(4);
        check("t6_stale_tag_err", 64'(tag_err_o), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            pend_q[0].push_back(16'h5000 + 16'(i));
            exp_issue_q.push_back({3'b001, 3'(i - 1), 16'h5000 + 16'(i)});
        end
        wait_drain("t6_tags_free_drain", 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
